// File: rtl/emu_time_scheduler.sv
// Central emulation-time scheduler: picks the earliest valid requester time, advances global time, pulses fire.
// Optional EMU_STOP_TIME_EN adds stop_time/done: events beyond stop_time end the run in DONE.
module emu_time_scheduler #(
  parameter int N         = 4,
  parameter int TIME_BITS = 40,
  parameter int CNT_BITS  = 32
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [N-1:0]           req_valid,
  input  logic [N*TIME_BITS-1:0] req_time,
  output logic [N-1:0]           fire,
  output logic [TIME_BITS-1:0]   time_curr,
  output logic [TIME_BITS-1:0]   time_next,
  output logic                   busy,
  output logic                   starved,
  output logic                   err_nonmono,
  output logic [CNT_BITS-1:0]    event_cnt,
  output logic [2:0]             state_dbg
`ifdef EMU_STOP_TIME_EN
  ,
  input  logic [TIME_BITS-1:0]   stop_time,
  output logic                   done
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_ADVANCE = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [TIME_BITS-1:0] time_curr_q, time_curr_d;
  logic [TIME_BITS-1:0] time_next_q, time_next_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [N-1:0]         fire_q, fire_d;
  logic                 err_q, err_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
`ifdef EMU_STOP_TIME_EN
  logic                 done_q, done_d;
`endif

  logic                 any_valid;
  logic [TIME_BITS-1:0] min_time;
  logic [N-1:0]         min_mask;

  // Linear min search over valid requesters; invalid slots never influence the result.
  always_comb begin
    any_valid = 1'b0;
    min_time  = '0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && (!any_valid || (req_time[i*TIME_BITS +: TIME_BITS] < min_time))) begin
        min_time  = req_time[i*TIME_BITS +: TIME_BITS];
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    min_mask = '0;
    for (int i = 0; i < N; i++) begin
      min_mask[i] = req_valid[i] && (req_time[i*TIME_BITS +: TIME_BITS] == min_time);
    end
  end

  always_comb begin
    state_d     = state_q;
    time_curr_d = time_curr_q;
    time_next_d = time_next_q;
    mask_d      = mask_q;
    fire_d      = '0;
    err_d       = err_q;
    cnt_d       = cnt_q;
`ifdef EMU_STOP_TIME_EN
    done_d      = done_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (any_valid) begin
          time_next_d = min_time;
          mask_d      = min_mask;
          state_d     = S_ADVANCE;
        end
      end
      // A captured event always completes here regardless of run.
      S_ADVANCE: begin
        if (time_next_q < time_curr_q) begin
          err_d   = 1'b1;
          state_d = S_HALT;
`ifdef EMU_STOP_TIME_EN
        end else if (time_next_q > stop_time) begin
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          time_curr_d = time_next_q;
          fire_d      = mask_q;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = run ? S_SCAN : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_curr_q <= '0;
      time_next_q <= '0;
      mask_q      <= '0;
      fire_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef EMU_STOP_TIME_EN
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      time_curr_q <= time_curr_d;
      time_next_q <= time_next_d;
      mask_q      <= mask_d;
      fire_q      <= fire_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef EMU_STOP_TIME_EN
      done_q      <= done_d;
`endif
    end
  end

  assign fire        = fire_q;
  assign time_curr   = time_curr_q;
  assign time_next   = time_next_q;
  assign err_nonmono = err_q;
  assign event_cnt   = cnt_q;
  assign state_dbg   = state_q;
  assign busy        = (state_q == S_SCAN) || (state_q == S_ADVANCE) || (state_q == S_SETTLE);
  assign starved     = (state_q == S_SCAN) && run && !(|req_valid);
`ifdef EMU_STOP_TIME_EN
  assign done        = done_q;
`endif

endmodule

// File: tb/tb_emu_time_scheduler.sv
// Directed bench for emu_time_scheduler: expected fire/time pairs queued by stimulus, checked by a fire monitor.
module tb_emu_time_scheduler;

  localparam int N  = 4;
  localparam int TB = 40;
  localparam int CB = 32;
  localparam int W  = N + TB;

  logic            clk_sys;
  logic            rst_n;
  logic            run;
  logic [N-1:0]    req_valid;
  logic [N*TB-1:0] req_time;
  logic [N-1:0]    fire;
  logic [TB-1:0]   time_curr;
  logic [TB-1:0]   time_next;
  logic            busy;
  logic            starved;
  logic            err_nonmono;
  logic [CB-1:0]   event_cnt;
  logic [2:0]      state_dbg;
`ifdef EMU_STOP_TIME_EN
  logic [TB-1:0]   stop_time;
  logic            done;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  emu_time_scheduler #(.N(N), .TIME_BITS(TB), .CNT_BITS(CB)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .run         (run),
    .req_valid   (req_valid),
    .req_time    (req_time),
    .fire        (fire),
    .time_curr   (time_curr),
    .time_next   (time_next),
    .busy        (busy),
    .starved     (starved),
    .err_nonmono (err_nonmono),
    .event_cnt   (event_cnt),
    .state_dbg   (state_dbg)
`ifdef EMU_STOP_TIME_EN
    ,
    .stop_time   (stop_time),
    .done        (done)
`endif
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int idx, input logic v, input logic [TB-1:0] t);
    req_valid[idx]          = v;
    req_time[idx*TB +: TB]  = t;
  endtask

  task automatic push_exp(input logic [N-1:0] f, input logic [TB-1:0] t);
    exp_q.push_back({f, t});
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_fire(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      step();
      if (fire != '0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s timeout actual=no_fire expected=fire within %0d cycles", name, max_cycles);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_sys) begin
    if (fire !== '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_fire actual=%b time_curr=%0d expected=no_fire", fire, time_curr);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("mon_fire", 64'(fire), 64'(e[W-1:TB]));
        check("mon_time_curr", 64'(time_curr), 64'(e[TB-1:0]));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b1;
    req_valid = '0;
    req_time  = '0;
`ifdef EMU_STOP_TIME_EN
    stop_time = '0;
`endif
    repeat (3) step();
    check("rst_fire", 64'(fire), 0);
    check("rst_time_curr", 64'(time_curr), 0);
    check("rst_time_next", 64'(time_next), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_starved", 64'(starved), 0);
    check("rst_err", 64'(err_nonmono), 0);
    check("rst_cnt", 64'(event_cnt), 0);
    check("rst_state", 64'(state_dbg), 0);

    // earliest of two, then next after requester 0 moves on
    run   = 1'b0;
    rst_n = 1'b1;
    step();
    check("idle_hold", 64'(state_dbg), 0);
    set_req(0, 1'b1, 10);
    set_req(1, 1'b1, 20);
    push_exp(4'b0001, 10);
    run = 1'b1;
    step();
    check("scan_state", 64'(state_dbg), 1);
    check("scan_busy", 64'(busy), 1);
    step();
    check("no_early_fire", 64'(fire), 0);
    step();
    check("lat_fire", 64'(fire), 4'b0001);
    check("lat_time", 64'(time_curr), 10);
    set_req(0, 1'b1, 30);
    push_exp(4'b0010, 20);
    wait_fire("second_fire", 10);
    check("t2_time", 64'(time_curr), 20);
    check("t2_cnt", 64'(event_cnt), 2);
    check("t2_time_next", 64'(time_next), 20);

    // tie between requesters 1 and 3
    set_req(0, 1'b0, 30);
    set_req(1, 1'b1, 50);
    set_req(3, 1'b1, 50);
    push_exp(4'b1010, 50);
    wait_fire("tie_fire", 10);
    check("tie_time", 64'(time_curr), 50);
    req_valid = '0;
    step();
    check("tie_one_cycle", 64'(fire), 0);

    // starvation, then run dropped during ADVANCE
    check("starved", 64'(starved), 1);
    check("starved_busy", 64'(busy), 1);
    step();
    check("starved_hold", 64'(state_dbg), 1);
    set_req(0, 1'b1, 70);
    push_exp(4'b0001, 70);
    step();
    check("adv_state", 64'(state_dbg), 2);
    run = 1'b0;
    step();
    check("norun_fire", 64'(fire), 4'b0001);
    set_req(0, 1'b0, 70);
    step();
    check("norun_idle", 64'(state_dbg), 0);
    check("norun_busy", 64'(busy), 0);
    check("norun_cnt", 64'(event_cnt), 4);

    // equal time is legal, then a time going backwards halts
    set_req(2, 1'b1, 100);
    push_exp(4'b0100, 100);
    run = 1'b1;
    wait_fire("t100_fire", 10);
    check("t100_time", 64'(time_curr), 100);
    push_exp(4'b0100, 100);
    wait_fire("equal_fire", 10);
    check("equal_err", 64'(err_nonmono), 0);
    check("equal_cnt", 64'(event_cnt), 6);
    set_req(2, 1'b1, 90);
    repeat (4) step();
    check("nonmono_err", 64'(err_nonmono), 1);
    check("nonmono_halt", 64'(state_dbg), 4);
    check("nonmono_time", 64'(time_curr), 100);
    check("nonmono_next", 64'(time_next), 90);
    check("nonmono_busy", 64'(busy), 0);
    check("nonmono_cnt", 64'(event_cnt), 6);
    check("nonmono_fire", 64'(fire), 0);

    // async reset in the middle of ADVANCE
    rst_n = 1'b0;
    #1;
    check("areset_err", 64'(err_nonmono), 0);
    step();
    req_valid = '0;
    set_req(2, 1'b1, 5);
    rst_n = 1'b1;
    step();
    step();
    check("pre_reset_adv", 64'(state_dbg), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_state", 64'(state_dbg), 0);
    check("midreset_next", 64'(time_next), 0);
    check("midreset_cnt", 64'(event_cnt), 0);
    step();
    check("midreset_fire", 64'(fire), 0);
    check("midreset_time", 64'(time_curr), 0);

`ifdef EMU_STOP_TIME_EN
    req_valid = '0;
    stop_time = 100;
    set_req(0, 1'b1, 60);
    push_exp(4'b0001, 60);
    rst_n = 1'b1;
    wait_fire("stop_fire60", 10);
    set_req(0, 1'b1, 120);
    repeat (4) step();
    check("stop_done", 64'(done), 1);
    check("stop_state", 64'(state_dbg), 5);
    check("stop_time_curr", 64'(time_curr), 60);
    check("stop_busy", 64'(busy), 0);
    rst_n = 1'b0;
    step();
    stop_time = 120;
    push_exp(4'b0001, 120);
    rst_n = 1'b1;
    wait_fire("stop_eq_fire", 10);
    check("stop_eq_time", 64'(time_curr), 120);
    check("stop_eq_done", 64'(done), 0);
`endif

    repeat (3) step();
    check("exp_q_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
